// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access size codes and arbiter states.
package dmem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic {
    CPU_PRI   = 1'b0,
    DMA_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_align_chk.sv
// Per-port alignment/size legality check; purely combinational.
module dmem_align_chk
  import dmem_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    case (size)
      SZ_WORD: legal = (addr == 2'b00);
      SZ_HALF: legal = ~addr[0];
      SZ_BYTE: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the DataMemory port between the CPU MEM stage and a DMA/debug port,
// with CPU priority and a starvation-forced DMA grant.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic              stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [1:0]        dma_size,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_err,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemWrite,
  output logic              MemRead,
  output logic [1:0]        Load,
  output logic [1:0]        Store,
  input  logic [DATA_W-1:0] ReadData
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic cpu_legal, dma_legal;
  logic cpu_lreq, dma_lreq;
  logic cpu_win, dma_win;

  dmem_align_chk u_cpu_chk (.size(cpu_size), .addr(cpu_addr[1:0]), .legal(cpu_legal));
  dmem_align_chk u_dma_chk (.size(dma_size), .addr(dma_addr[1:0]), .legal(dma_legal));

  assign cpu_lreq = cpu_req & cpu_legal;
  assign dma_lreq = dma_req & dma_legal;

  // Illegal requests are acknowledged immediately in any state and never use a memory slot.
  assign cpu_err = cpu_req & ~cpu_legal;
  assign dma_err = dma_req & ~dma_legal;
  assign cpu_gnt = cpu_win | cpu_err;
  assign dma_gnt = dma_win | dma_err;
  assign stall   = cpu_req & ~cpu_gnt;

  always_comb begin
    cpu_win      = 1'b0;
    dma_win      = 1'b0;
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      CPU_PRI: begin
        if (cpu_lreq) begin
          cpu_win = 1'b1;
          if (dma_lreq) begin
            if (starve_cnt_q == LIMIT_M1) state_d = DMA_FORCE;
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else if (dma_lreq) begin
          dma_win      = 1'b1;
          starve_cnt_d = '0;
        end
      end
      DMA_FORCE: begin
        // One forced slot: granted if DMA still asks legally, otherwise abandoned.
        dma_win      = dma_lreq;
        starve_cnt_d = '0;
        state_d      = CPU_PRI;
      end
      default: state_d = CPU_PRI;
    endcase
  end

  always_comb begin
    Address   = '0;
    WriteData = '0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    Load      = '0;
    Store     = '0;
    if (cpu_win) begin
      Address   = cpu_addr;
      WriteData = cpu_wdata;
      MemWrite  = cpu_we;
      MemRead   = ~cpu_we;
      Load      = cpu_size;
      Store     = cpu_size;
    end else if (dma_win) begin
      Address   = dma_addr;
      WriteData = dma_wdata;
      MemWrite  = dma_we;
      MemRead   = ~dma_we;
      Load      = dma_size;
      Store     = dma_size;
    end
  end

  always_comb begin
    cpu_rvalid_d = cpu_win & ~cpu_we;
    dma_rvalid_d = dma_win & ~dma_we;
    cpu_rdata_d  = cpu_rvalid_d ? ReadData : cpu_rdata_q;
    dma_rdata_d  = dma_rvalid_d ? ReadData : dma_rdata_q;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= CPU_PRI;
      starve_cnt_q <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rvalid = dma_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and access sequencer in front of the `DataMemory` block. It shares the single data-memory port between the pipeline MEM stage (CPU port) and a DMA/debug port. It drives the memory's Address/WriteData/MemWrite/MemRead/Load/Store encoding, registers read data, flags misaligned accesses and stalls the pipeline when the CPU is not granted. It sits between the MEM stage and `DataMemory` in the processor top level.

## Interface
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: data width.
- `STARVE_LIMIT`, 4: consecutive denied DMA cycles before DMA gets a forced grant (≥1).
- `Clk` in 1: the only clock. All state updates on the rising edge.
- `Rst_n` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: CPU access request, level, held until granted.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_size` in 2: 00 word, 01 halfword, 10 byte; 11 is illegal.
- `cpu_addr` in ADDR_W: byte address.
- `cpu_wdata` in DATA_W: store data.
- `cpu_gnt` out 1: access issued to memory this cycle.
- `cpu_rvalid` out 1: one-cycle pulse when `cpu_rdata` is valid.
- `cpu_rdata` out DATA_W: registered load data.
- `cpu_err` out 1: one-cycle pulse, request rejected as misaligned or illegal size.
- `stall` out 1: equals `cpu_req & ~cpu_gnt`, combinational.
- `dma_req`, `dma_we`, `dma_size`, `dma_addr`, `dma_wdata`: in, same widths and meaning as the CPU port.
- `dma_gnt`, `dma_rvalid`, `dma_rdata`, `dma_err`: out, same widths and meaning as the CPU port.
- `Address` out 32, `WriteData` out 32, `MemWrite` out 1, `MemRead` out 1: memory-side command.
- `Load` out 2, `Store` out 2: memory-side size code, 00 word, 01 half, 10 byte.
- `ReadData` in 32: memory's combinational read data.

## Operation
- **Alignment check**, per port, combinational:
  - word requires `addr[1:0]`=00.
  - half requires `addr[0]`=0.
  - byte is always legal.
  - size 11 is always illegal.
- **Illegal request handling:**
  - An illegal request is accepted without touching memory: the port's `gnt`=1 and `err`=1 in the same cycle.
  - MemRead and MemWrite stay 0 for that port.
  - An illegal request does not count as a memory grant for arbitration.
- **FSM states:** CPU_PRI (reset state) and DMA_FORCE.
- **CPU_PRI:**
  - Granting: a legal `cpu_req` wins; otherwise a legal `dma_req` wins.
  - `starve_cnt` increments on each cycle a legal `dma_req` is denied, and clears on any DMA grant.
  - When `starve_cnt` reaches STARVE_LIMIT-1 while the DMA is again denied, go to DMA_FORCE.
- **DMA_FORCE:**
  - A legal `dma_req` wins unconditionally; the CPU is stalled.
  - After that grant, clear `starve_cnt` and return to CPU_PRI.
  - If `dma_req` drops while in DMA_FORCE, return to CPU_PRI with no grant and clear `starve_cnt`.
- **Memory command:**
  - The command is driven combinationally from the winning port: Address=addr, WriteData=wdata, MemWrite=we, MemRead=~we, Load=Store=size.
  - With no winner, all command outputs are 0.
- **Read data:** on a granted load, `ReadData` is captured into the winner's `rdata` register and `rvalid` pulses the next cycle. The other port's `rdata` holds its value.
- **Writes:** a granted store commits at the same rising edge as the grant. There is no `rvalid` for stores.
- **Simultaneous legal requests in CPU_PRI:** the CPU wins and the DMA counts as starved.
- **Simultaneous errors:** both ports may report errors in the same cycle, since no memory slot is used.
- **Reset mid-operation:**
  - State returns to CPU_PRI and `starve_cnt`=0.
  - Every output register clears: `rvalid`=0, `rdata`=0, `err`=0.
  - A pending `rvalid` is dropped.

## Timing
- **Reset values:** `cpu_gnt`, `dma_gnt` and `stall` follow their inputs. With requests low, every output is 0, including the memory command. The registered outputs (`*_rvalid`, `*_rdata`) are 0.
- **Grant:** combinational in the request cycle, so the zero-wait path is 0 extra cycles.
- **Load latency:** `rvalid`/`rdata` arrive 1 cycle after the grant.
- **Error:** `err` is combinational in the request cycle.
- **Back-to-back grants:** allowed every cycle. Granting a load and a store to the same address on consecutive cycles gives read-before-write order.
- **Worst-case DMA wait:** STARVE_LIMIT cycles from its first legal request cycle.

## Structure
- **Shared package `dmem_pkg`:**
  - size codes SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10.
  - arbiter state enum {CPU_PRI, DMA_FORCE}.
- **Sub-module `dmem_align_chk`:** inputs (size, addr[1:0]), output legal. Instantiate it once per port.

## Test plan
- **CPU-only load:** CPU loads word @0x10 while memory word 4 = 0x4 → `cpu_gnt`=1 in the same cycle; next cycle `cpu_rvalid`=1 and `cpu_rdata`=0x00000004; `stall` stays 0.
- **Contention then force:** with STARVE_LIMIT=4, CPU and DMA both request continuously → CPU granted for cycles 0–3; DMA granted in cycle 4 with `stall`=1; CPU granted again in cycle 5.
- **Misaligned access:** CPU stores a half @0x3 → `cpu_err`=1 and `cpu_gnt`=1; MemWrite=0; memory unchanged; a concurrent legal DMA request is granted that cycle.
- **DMA store then CPU load:** DMA stores word 0xDEADBEEF @0x8, then CPU loads @0x8 the next cycle → `cpu_rdata`=0xDEADBEEF.
- **Reset mid-operation:** assert `Rst_n`=0 in the cycle between a granted load and its `rvalid` → `rvalid` never pulses, outputs read 0, FSM is in CPU_PRI after release.
- **DMA drops request in DMA_FORCE:** deassert `dma_req` after entering DMA_FORCE → no DMA grant, CPU granted next cycle, `starve_cnt`=0.
